// File: rtl/dds_wave_gen.sv
// dds_wave_gen: direct-digital-synthesis waveform generator.
//   A phase accumulator drives a quarter-wave sine LUT and three arithmetic shapes (square,
//   triangle, sawtooth). The result is scaled by a gain and sent out as unsigned offset-binary.
//   New settings are offered through a valid/ready handshake into a shadow register. They become
//   active on a phase wrap, so a single period never mixes two configurations.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   enable                  advance accumulator and produce one sample per cycle
//   cfg_valid / cfg_ready   config handshake; cfg_ready is high while the shadow register is empty
//   freq_control            phase increment per sample
//   phase_offset            phase added before lookup
//   amplitude               gain = (amplitude+1) / 2**AMP_WIDTH
//   mode                    0 sine, 1 square, 2 triangle, 3 sawtooth
//   wave_out / wave_valid   sample output and its strobe (3-cycle latency from the accumulator)
//   cycle_wrap              pulses with the first sample after an accumulator overflow
module dds_wave_gen #(
  parameter int unsigned PHASE_WIDTH    = 16,
  parameter int unsigned LUT_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned AMP_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] freq_control,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  input  logic [AMP_WIDTH-1:0]   amplitude,
  input  logic [1:0]             mode,
  output logic [DATA_WIDTH-1:0]  wave_out,
  output logic                   wave_valid,
  output logic                   cycle_wrap
);

  typedef enum logic [1:0] {ModeSine, ModeSquare, ModeTriangle, ModeSaw} mode_e;

  localparam int unsigned M        = 2 ** (DATA_WIDTH - 1);
  localparam int unsigned LutDepth = 2 ** LUT_ADDR_WIDTH;
  localparam int unsigned ProdW    = DATA_WIDTH + AMP_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0]        Mid  = DATA_WIDTH'(M);
  localparam logic signed [DATA_WIDTH-1:0] SMax = DATA_WIDTH'(M - 1);
  localparam logic signed [DATA_WIDTH-1:0] SMin = -SMax;

  // Quarter-wave table, sampled at bin centres so the fold needs no special endpoints.
  logic [DATA_WIDTH-1:0] lut [LutDepth];
  for (genvar i = 0; i < LutDepth; i++) begin : g_lut
    localparam real Ang = 3.14159265358979 * (real'(i) + 0.5) / (2.0 * real'(LutDepth));
    localparam int  Val = $rtoi(real'(M - 1) * $sin(Ang) + 0.5);
    assign lut[i] = DATA_WIDTH'(Val);
  end

  // Accumulator and active / shadow configuration
  logic [PHASE_WIDTH-1:0] acc_q, freq_q, offset_q, sh_freq_q, sh_offset_q;
  logic [AMP_WIDTH-1:0]   amp_q, sh_amp_q;
  mode_e                  mode_q, sh_mode_q;
  logic                   wrap_q, sh_full_q;

  // Pipeline: S1 = folded address / top phase bits, S2 = LUT data / shape value
  logic                      valid1_q, wrap1_q, neg1_q;
  logic [LUT_ADDR_WIDTH-1:0] addr1_q;
  logic [DATA_WIDTH:0]       pt1_q;
  mode_e                     mode1_q;
  logic [AMP_WIDTH-1:0]      amp1_q, amp2_q;
  logic                      valid2_q, wrap2_q, neg2_q, sine2_q;
  logic [DATA_WIDTH-1:0]     lut2_q;
  logic signed [DATA_WIDTH-1:0] alt2_q;

  logic [PHASE_WIDTH:0]         acc_sum;
  logic                         carry, xfer, accept;
  logic [PHASE_WIDTH-1:0]       p0;
  logic [1:0]                   quad0;
  logic [LUT_ADDR_WIDTH-1:0]    a0, addr0;
  logic [DATA_WIDTH-1:0]        tri_t;
  logic signed [DATA_WIDTH-1:0] tri_s, saw_s, alt_s, slut, s3;
  logic [AMP_WIDTH:0]           gain;
  logic signed [ProdW-1:0]      prod, scaled;
  logic [DATA_WIDTH-1:0]        wave_next;
  logic                         unused_bits;

  assign cfg_ready = ~sh_full_q;

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, freq_q};
    carry   = enable & acc_sum[PHASE_WIDTH];
    // Idle or zero-frequency generators never wrap, so apply the shadow at once there.
    xfer    = sh_full_q & (~enable | (freq_q == '0) | carry);
    accept  = cfg_valid & ~sh_full_q;

    p0    = acc_q + offset_q;
    quad0 = p0[PHASE_WIDTH-1 -: 2];
    a0    = p0[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    addr0 = quad0[0] ? ~a0 : a0;

    // pt1_q holds p[MSB] followed by the next DATA_WIDTH bits
    tri_t = pt1_q[DATA_WIDTH] ? ~pt1_q[DATA_WIDTH-1:0] : pt1_q[DATA_WIDTH-1:0];
    tri_s = $signed({~tri_t[DATA_WIDTH-1], tri_t[DATA_WIDTH-2:0]});       // t - M
    saw_s = $signed({~pt1_q[DATA_WIDTH], pt1_q[DATA_WIDTH-1:1]});         // t - M
    alt_s = '0;
    unique case (mode1_q)
      ModeSquare:   alt_s = pt1_q[DATA_WIDTH] ? SMin : SMax;
      ModeTriangle: alt_s = (tri_s < SMin) ? SMin : tri_s;
      ModeSaw:      alt_s = (saw_s < SMin) ? SMin : saw_s;
      default:      alt_s = '0;
    endcase

    slut      = $signed(lut2_q);
    s3        = sine2_q ? (neg2_q ? -slut : slut) : alt2_q;
    gain      = {1'b0, amp2_q} + {{AMP_WIDTH{1'b0}}, 1'b1};
    prod      = ProdW'(s3) * ProdW'($signed({1'b0, gain}));
    scaled    = prod >>> AMP_WIDTH;  // floors toward -inf
    wave_next = Mid + scaled[DATA_WIDTH-1:0];
  end

  assign unused_bits = ^{p0, scaled};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      wrap_q      <= 1'b0;
      freq_q      <= '0;
      offset_q    <= '0;
      amp_q       <= '1;
      mode_q      <= ModeSine;
      sh_full_q   <= 1'b0;
      sh_freq_q   <= '0;
      sh_offset_q <= '0;
      sh_amp_q    <= '0;
      sh_mode_q   <= ModeSine;
      valid1_q    <= 1'b0;
      wrap1_q     <= 1'b0;
      neg1_q      <= 1'b0;
      addr1_q     <= '0;
      pt1_q       <= '0;
      mode1_q     <= ModeSine;
      amp1_q      <= '0;
      valid2_q    <= 1'b0;
      wrap2_q     <= 1'b0;
      neg2_q      <= 1'b0;
      sine2_q     <= 1'b0;
      lut2_q      <= '0;
      alt2_q      <= '0;
      amp2_q      <= '0;
      wave_out    <= Mid;
      wave_valid  <= 1'b0;
      cycle_wrap  <= 1'b0;
    end else begin
      if (enable) begin
        acc_q  <= acc_sum[PHASE_WIDTH-1:0];
        wrap_q <= acc_sum[PHASE_WIDTH];
      end
      if (xfer) begin
        freq_q    <= sh_freq_q;
        offset_q  <= sh_offset_q;
        amp_q     <= sh_amp_q;
        mode_q    <= sh_mode_q;
        sh_full_q <= 1'b0;
      end else if (accept) begin
        sh_freq_q   <= freq_control;
        sh_offset_q <= phase_offset;
        sh_amp_q    <= amplitude;
        sh_mode_q   <= mode_e'(mode);
        sh_full_q   <= 1'b1;
      end

      // Mode and gain ride along with each sample so a cfg swap never splits one.
      valid1_q <= enable;
      wrap1_q  <= enable & wrap_q;
      neg1_q   <= quad0[1];
      addr1_q  <= addr0;
      pt1_q    <= p0[PHASE_WIDTH-1 -: DATA_WIDTH+1];
      mode1_q  <= mode_q;
      amp1_q   <= amp_q;

      valid2_q <= valid1_q;
      wrap2_q  <= wrap1_q;
      neg2_q   <= neg1_q;
      sine2_q  <= (mode1_q == ModeSine);
      lut2_q   <= lut[addr1_q];
      alt2_q   <= alt_s;
      amp2_q   <= amp1_q;

      if (valid2_q) wave_out <= wave_next;
      wave_valid <= valid2_q;
      cycle_wrap <= valid2_q & wrap2_q;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed bench for dds_wave_gen (16-bit phase, 256-entry LUT, 8-bit data/gain).
//   A cycle-level reference model of accumulator and config handshake pushes the expected sample
//   for every enabled cycle into a queue; each sample the DUT emits is popped and compared.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        reset, enable, cfg_valid, cfg_ready;
  logic [15:0] freq_control, phase_offset;
  logic [7:0]  amplitude, wave_out;
  logic [1:0]  mode;
  logic        wave_valid, cycle_wrap;

  always #5 clk = ~clk;

  dds_wave_gen #(
    .PHASE_WIDTH   (16),
    .LUT_ADDR_WIDTH(8),
    .DATA_WIDTH    (8),
    .AMP_WIDTH     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .freq_control(freq_control),
    .phase_offset(phase_offset),
    .amplitude   (amplitude),
    .mode        (mode),
    .wave_out    (wave_out),
    .wave_valid  (wave_valid),
    .cycle_wrap  (cycle_wrap)
  );

  typedef struct {
    int   wave;
    logic wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_exp = 128;

  // Reference model state
  int m_acc, m_freq, m_off, m_amp, m_mode;
  int sh_freq, sh_off, sh_amp, sh_mode;
  bit m_wrap, sh_full;

  function automatic int exp_wave(int p, int md, int amp);
    int  s, q, a, addr, lut, u;
    real ang;
    case (md)
      0: begin
        q    = (p >> 14) & 3;
        a    = (p >> 6) & 255;
        addr = (q & 1) ? 255 - a : a;
        ang  = 3.14159265358979 * (addr + 0.5) / 512.0;
        lut  = $rtoi(127.0 * $sin(ang) + 0.5);
        s    = (q & 2) ? -lut : lut;
      end
      1: s = (p & 'h8000) ? -127 : 127;
      2: begin
        u = (p & 'h8000) ? (~p) & 'h7FFF : p & 'h7FFF;
        s = (u >> 7) - 128;
      end
      default: s = (p >> 8) - 128;
    endcase
    if (s < -127) s = -127;
    return 128 + ((s * (amp + 1)) >>> 8);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_freq = 0; m_off = 0; m_amp = 255; m_mode = 0;
    m_wrap = 1'b0; sh_full = 1'b0;
  endtask

  // One clock: push expectation, advance model at the edge, then compare DUT outputs.
  task automatic tick();
    exp_t e;
    bit   carry, xfer;
    if (!reset && enable) begin
      e.wave = exp_wave((m_acc + m_off) & 'hFFFF, m_mode, m_amp);
      e.wrap = m_wrap;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      carry = enable && (m_acc + m_freq > 'hFFFF);
      xfer  = sh_full && (!enable || m_freq == 0 || carry);
      if (enable) begin
        m_acc  = (m_acc + m_freq) & 'hFFFF;
        m_wrap = carry;
      end
      if (xfer) begin
        m_freq = sh_freq; m_off = sh_off; m_amp = sh_amp; m_mode = sh_mode;
        sh_full = 1'b0;
      end else if (cfg_valid && !sh_full) begin
        sh_freq = freq_control; sh_off = phase_offset; sh_amp = amplitude; sh_mode = mode;
        sh_full = 1'b1;
      end
    end
    #1;
    if (wave_valid === 1'b1) begin
      check("scoreboard_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_exp = e.wave;
        check("wave_out", wave_out, e.wave);
        check("cycle_wrap", cycle_wrap, e.wrap);
      end
    end else begin
      check("cycle_wrap_idle", cycle_wrap, 0);
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic offer(int f, int o, int a, int md);
    freq_control = 16'(f);
    phase_offset = 16'(o);
    amplitude    = 8'(a);
    mode         = 2'(md);
    cfg_valid    = 1'b1;
    tick();
    cfg_valid    = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    ticks(2);
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    freq_control = '0; phase_offset = '0; amplitude = '0; mode = '0;
    model_reset();

    // Reset state
    ticks(2);
    reset = 1'b0;
    tick();
    check("rst_wave_out", wave_out, 128);
    check("rst_wave_valid", wave_valid, 0);
    check("rst_cycle_wrap", cycle_wrap, 0);
    check("rst_cfg_ready", cfg_ready, 1);

    // Sine, freq 256, unity gain: latency, first sample, full periods via scoreboard
    offer(256, 0, 255, 0);
    check("cfg_ready_after_accept", cfg_ready, 0);
    tick();
    check("cfg_ready_after_xfer", cfg_ready, 1);
    enable = 1'b1;
    ticks(2);
    check("latency_not_yet", wave_valid, 0);
    tick();
    check("latency_valid", wave_valid, 1);
    check("sine_first", wave_out, 128);
    ticks(600);

    // Phase offsets
    do_reset();
    offer(256, 'h4000, 255, 0);
    tick();
    enable = 1'b1;
    ticks(3);
    check("offset4000_first", wave_out, 255);
    ticks(40);
    do_reset();
    offer(256, 'h8000, 255, 0);
    tick();
    enable = 1'b1;
    ticks(3);
    check("offset8000_first", wave_out, 128);
    tick();
    check("offset8000_second", wave_out, 124);
    ticks(40);

    // Square at half gain, then triangle and sawtooth
    do_reset();
    offer(256, 0, 127, 1);
    tick();
    enable = 1'b1;
    ticks(3);
    check("square_first", wave_out, 191);
    ticks(300);
    enable = 1'b0;
    ticks(3);
    check("drained_valid", wave_valid, 0);
    check("drained_hold", wave_out, last_exp);
    offer(1024, 'h1234, 200, 2);
    tick();
    enable = 1'b1;
    ticks(100);
    enable = 1'b0;
    offer(1536, 0, 255, 3);
    tick();
    enable = 1'b1;
    ticks(100);

    // Mid-cycle frequency change waits for the wrap
    do_reset();
    offer(256, 0, 255, 0);
    tick();
    enable = 1'b1;
    ticks(100);
    offer(512, 0, 255, 0);
    check("midcycle_pending", cfg_ready, 0);
    ticks(50);
    check("midcycle_still_pending", cfg_ready, 0);
    ticks(200);
    check("midcycle_applied", cfg_ready, 1);

    // Offer accepted on the wrap cycle applies one full period later
    for (int i = 0; i < 300 && !(m_acc + m_freq > 'hFFFF); i++) tick();
    offer(1024, 0, 255, 0);
    check("wrapcycle_accepted", cfg_ready, 0);
    ticks(127);
    check("wrapcycle_still_pending", cfg_ready, 0);
    tick();
    check("wrapcycle_applied", cfg_ready, 1);
    ticks(80);

    // Pending shadow discarded by reset
    offer(4096, 'h100, 50, 1);
    check("pending_before_reset", cfg_ready, 0);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    check("post_rst_cfg_ready", cfg_ready, 1);
    check("post_rst_wave_valid", wave_valid, 0);
    check("post_rst_wave_out", wave_out, 128);
    enable = 1'b1;
    ticks(3);
    check("post_rst_default_valid", wave_valid, 1);
    check("post_rst_default_out", wave_out, 128);
    ticks(30);

    enable = 1'b0;
    ticks(5);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
